instr_loader: RTL and testbench

//  Boot-time program loader and writer side of the instruction-memory AXI port (port B of instr_mem_gen).

---
 rtl/instr_loader.sv | 146 ++++++++++++++
 tb/tb_instr_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader and writer side of instruction-memory port B.
//   Assembles a little-endian byte stream into 32-bit words. The stream is
//   LEN(N), then N words, then CSUM (XOR of all N words). The words are written
//   to consecutive locations and then read back, and both XORs are checked.
//   The core is held in reset unless the last load passed.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_start                     arm pulse (IDLE/DONE/ERR only)
//   i_s_valid/i_s_data/o_s_ready  byte stream handshake
//   o_axi_instr_en/we/addr/din  memory port B request; i_axi_instr_dout read data (1-cycle latency)
//   o_core_rst                  active-high pipeline reset
//   o_busy/o_done/o_error       status levels
//   o_words_loaded              words written in the current/last load
module instr_loader #(
  parameter int INSTR_MEM_LEN = 15,
  parameter int INSTR_WIDTH   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_s_valid,
  input  logic [7:0]               i_s_data,
  output logic                     o_s_ready,
  output logic                     o_axi_instr_en,
  output logic [3:0]               o_axi_instr_we,
  output logic [INSTR_MEM_LEN-1:0] o_axi_instr_addr,
  output logic [INSTR_WIDTH-1:0]   o_axi_instr_din,
  input  logic [INSTR_WIDTH-1:0]   i_axi_instr_dout,
  output logic                     o_core_rst,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [INSTR_MEM_LEN-2:0] o_words_loaded
);
  localparam int MAX_WORDS = 2**(INSTR_MEM_LEN-2);
  localparam int CW        = INSTR_MEM_LEN-1;   // holds 0..MAX_WORDS
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_VERIFY, S_VCHK, S_DONE, S_ERR
  } state_t;

  state_t                   r_state, w_nstate;
  logic [1:0]               r_bcnt;
  logic [INSTR_WIDTH-1:0]   r_word, r_wxor, r_rxor, r_csum;
  logic [CW-1:0]            r_n, r_idx, r_ridx;
  logic                     r_rvld;
  logic                     r_s_ready, r_en, r_core_rst, r_busy, r_done, r_error;
  logic [3:0]               r_we;
  logic [INSTR_MEM_LEN-1:0] r_addr;
  logic [INSTR_WIDTH-1:0]   r_din;

  logic                     w_acc, w_last, w_go;
  logic [INSTR_WIDTH-1:0]   w_word, w_rxor_fin;
  logic [CW-1:0]            w_idx_inc, w_ridx_nxt;

  assign w_acc      = r_s_ready & i_s_valid;
  assign w_last     = w_acc && (r_bcnt == 2'd3);
  // bytes shift in from the top so byte k ends up in bits [8k+7:8k]
  assign w_word     = {i_s_data, r_word[INSTR_WIDTH-1:8]};
  assign w_idx_inc  = r_idx + ONE;
  assign w_ridx_nxt = (r_state == S_VERIFY) ? r_ridx + ONE : '0;
  // the last read's data arrives during VCHK, so fold it in combinationally
  assign w_rxor_fin = r_rvld ? (r_rxor ^ i_axi_instr_dout) : r_rxor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_go     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (i_start) begin
          w_nstate = S_LEN;
          w_go     = 1'b1;
        end
      S_LEN:
        if (w_last) begin
          if (w_word > INSTR_WIDTH'(MAX_WORDS)) w_nstate = S_ERR;
          else if (w_word == '0)                w_nstate = S_CSUM;
          else                                  w_nstate = S_DATA;
        end
      S_DATA:   if (w_last) w_nstate = S_WRITE;
      S_WRITE:  w_nstate = (w_idx_inc < r_n) ? S_DATA : S_CSUM;
      S_CSUM:   if (w_last) w_nstate = S_VERIFY;
      S_VERIFY: if (r_n == '0 || r_ridx == r_n - ONE) w_nstate = S_VCHK;
      S_VCHK:   w_nstate = (w_rxor_fin == r_csum && r_wxor == r_csum) ? S_DONE : S_ERR;
      default:  w_nstate = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; outputs are computed from the next state
  // so each one reflects the state it belongs to with no combinational path out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcnt <= '0; r_word <= '0; r_wxor <= '0; r_rxor <= '0; r_csum <= '0;
      r_n <= '0; r_idx <= '0; r_ridx <= '0; r_rvld <= 1'b0;
      r_s_ready <= 1'b0; r_en <= 1'b0; r_we <= '0; r_addr <= '0; r_din <= '0;
      r_core_rst <= 1'b1; r_busy <= 1'b0; r_done <= 1'b0; r_error <= 1'b0;
    end else begin
      if (w_acc) begin
        r_word <= w_word;
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (w_go) begin
        r_bcnt <= '0; r_idx <= '0; r_n <= '0;
        r_wxor <= '0; r_rxor <= '0; r_csum <= '0;
      end
      if (r_state == S_LEN  && w_last) r_n    <= w_word[CW-1:0];
      if (r_state == S_CSUM && w_last) r_csum <= w_word;
      if (r_state == S_WRITE) begin
        r_wxor <= r_wxor ^ r_word;
        r_idx  <= w_idx_inc;
      end
      if (w_nstate == S_VERIFY) r_ridx <= w_ridx_nxt;
      r_rvld <= r_en && (r_we == 4'h0);
      if (r_rvld) r_rxor <= r_rxor ^ i_axi_instr_dout;

      r_s_ready  <= (w_nstate == S_LEN) || (w_nstate == S_DATA) || (w_nstate == S_CSUM);
      r_en       <= (w_nstate == S_WRITE) || (w_nstate == S_VERIFY && r_n != '0);
      r_we       <= (w_nstate == S_WRITE) ? 4'hF : 4'h0;
      r_din      <= (w_nstate == S_WRITE) ? w_word : '0;
      if (w_nstate == S_WRITE)                      r_addr <= {r_idx[CW-2:0], 2'b00};
      else if (w_nstate == S_VERIFY && r_n != '0)   r_addr <= {w_ridx_nxt[CW-2:0], 2'b00};
      else                                          r_addr <= '0;
      r_core_rst <= (w_nstate != S_DONE);
      r_busy     <= !(w_nstate == S_IDLE || w_nstate == S_DONE || w_nstate == S_ERR);
      r_done     <= (w_nstate == S_DONE);
      r_error    <= (w_nstate == S_ERR);
    end
  end

  assign o_s_ready        = r_s_ready;
  assign o_axi_instr_en   = r_en;
  assign o_axi_instr_we   = r_we;
  assign o_axi_instr_addr = r_addr;
  assign o_axi_instr_din  = r_din;
  assign o_core_rst       = r_core_rst;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_words_loaded   = r_idx;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: behavioural memory, stream driver, write/read monitor
// and a reference outcome computed from N, the word list and the checksum.
module tb_instr_loader;
  localparam int AW   = 15;
  localparam int MAXW = 2**(AW-2);

  logic          gclk = 1'b0;
  logic          grst_n;
  logic          start, s_valid;
  logic [7:0]    s_data;
  logic          s_ready, en, core_rst, busy, done, error;
  logic [3:0]    we;
  logic [AW-1:0] addr;
  logic [31:0]   din, dout;
  logic [AW-2:0] words_loaded;

  instr_loader #(.INSTR_MEM_LEN(AW), .INSTR_WIDTH(32)) dut (
    .i_clk(gclk), .i_rst_n(grst_n), .i_start(start),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready),
    .o_axi_instr_en(en), .o_axi_instr_we(we), .o_axi_instr_addr(addr),
    .o_axi_instr_din(din), .i_axi_instr_dout(dout),
    .o_core_rst(core_rst), .o_busy(busy), .o_done(done), .o_error(error),
    .o_words_loaded(words_loaded));

  always #5 gclk = ~gclk;

  // synchronous memory, 1-cycle read latency
  logic [31:0] mem [0:MAXW-1];
  always @(posedge gclk) begin
    if (en && we == 4'hF) mem[addr[AW-1:2]] <= din;
    if (en && we == 4'h0) dout <= mem[addr[AW-1:2]];
  end

  // monitor: logs writes, counts reads and illegal write-enable cycles
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int rd_cnt = 0, bad_cnt = 0;
  always @(negedge gclk) if (grst_n) begin
    if (we != 4'h0) begin
      wa_q.push_back(addr);
      wd_q.push_back(din);
      if (we != 4'hF || !en || s_ready) bad_cnt++;
    end
    if (en && we == 4'h0) rd_cnt++;
  end

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] wbuf [0:15];

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) while ($urandom_range(0, 1) == 1) begin
      s_valid = 1'b0;
      @(negedge gclk);
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 200) begin @(negedge gclk); t++; end
    if (t >= 200) check("byte_timeout", 64'(t), 64'(0));
    else @(negedge gclk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {s_ready, en, we, addr, din, core_rst, busy, done, error, words_loaded},
               {1'b0, 1'b0, 4'h0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, {(AW-1){1'b0}}});
  endtask

  // one full load; the reference decides the outcome from the stream contents
  task automatic run_load(input string tag, input int n, input logic [31:0] csum,
                          input bit gaps, input bit mid_start);
    int wl0, rd0, bad0, t;
    logic [31:0] x;
    bit ovf, pass;
    wl0 = wa_q.size(); rd0 = rd_cnt; bad0 = bad_cnt;
    ovf = (n > MAXW);
    x = 32'h0;
    if (!ovf) for (int i = 0; i < n; i++) x ^= wbuf[i];
    pass = !ovf && (x == csum);

    pulse_start();
    check({tag, "_armed"}, {busy, core_rst, done, error}, 4'b1100);
    send_word(32'(n), gaps);
    if (ovf) begin
      check({tag, "_ovf_err"}, {error, done, busy, core_rst}, 4'b1001);
      check({tag, "_ovf_wl"}, 64'(words_loaded), 64'(0));
    end else begin
      for (int i = 0; i < n; i++) begin
        send_word(wbuf[i], gaps);
        if (mid_start && i == 0) pulse_start();   // must be ignored
      end
      send_word(csum, gaps);
      t = 0;
      while (!(done || error) && t < 2000) begin @(negedge gclk); t++; end
      check({tag, "_finish"}, 64'(t < 2000), 64'(1));
      check({tag, "_status"}, {done, error, core_rst, busy}, {pass, !pass, !pass, 1'b0});
      check({tag, "_wl"}, 64'(words_loaded), 64'(n));
      check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(n));
      for (int i = 0; i < n; i++) check({tag, "_mem"}, 64'(mem[i]), 64'(wbuf[i]));
    end
    check({tag, "_nwrites"}, 64'(wa_q.size() - wl0), 64'(ovf ? 0 : n));
    for (int i = 0; i < n && wl0 + i < wa_q.size(); i++) begin
      check({tag, "_waddr"}, 64'(wa_q[wl0 + i]), 64'(i * 4));
      check({tag, "_wdata"}, 64'(wd_q[wl0 + i]), 64'(wbuf[i]));
    end
    check({tag, "_we_legal"}, 64'(bad_cnt - bad0), 64'(0));
    repeat (3) @(negedge gclk);
    check({tag, "_sticky"}, {done, error}, {pass, !ovf ? !pass : 1'b1});
  endtask

  initial begin
    int n;
    logic [31:0] x;
    grst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h0;
    repeat (2) @(negedge gclk);
    check_reset_outs("reset");
    grst_n = 1'b1;
    @(negedge gclk);
    check_reset_outs("idle");

    // directed: good load, bad checksum, overflow, empty loads
    wbuf[0] = 32'h0000_0013; wbuf[1] = 32'hDEAD_BEEF;
    run_load("t1", 2, 32'hDEAD_BEFC, 1'b0, 1'b0);
    wbuf[0] = 32'h0000_0013; wbuf[1] = 32'hDEAD_BEEF;
    run_load("t2", 2, 32'h0, 1'b0, 1'b0);
    run_load("t3", MAXW + 1, 32'h0, 1'b0, 1'b0);
    run_load("t4a", 0, 32'h0, 1'b0, 1'b0);
    run_load("t4b", 0, 32'h1, 1'b0, 1'b0);

    // N=3 back-to-back, then gapped with new contents and an ignored start
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    x = wbuf[0] ^ wbuf[1] ^ wbuf[2];
    run_load("t5a", 3, x, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    x = wbuf[0] ^ wbuf[1] ^ wbuf[2];
    run_load("t5b", 3, x, 1'b1, 1'b1);

    // randomized loads, some with a corrupted checksum
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      x = 32'h0;
      for (int i = 0; i < n; i++) begin wbuf[i] = $urandom; x ^= wbuf[i]; end
      if ($urandom_range(0, 3) == 0) x ^= 32'h1 << $urandom_range(0, 31);
      run_load("rnd", n, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in mid DATA (2 of 4 bytes of word 1), then a fresh load
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    grst_n = 1'b0;
    #1;
    check_reset_outs("t6_rst");
    @(negedge gclk);
    grst_n = 1'b1;
    @(negedge gclk);
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    x = wbuf[0] ^ wbuf[1] ^ wbuf[2];
    run_load("t6", 3, x, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
